ten_bit_shift_rx: RTL
=====================

TEN_BIT_SHIFT_RX -- requirements
Module: ten_bit_shift_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, meaning sample_en pulses per bit period; SHALL be even and >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_in  input  1  asynchronous serial line; idles high.
REQ-005 sample_en  input  1  one-clk pulse at OVERSAMPLE x bit rate; all frame timing SHALL advance only on sample_en.
REQ-006 data_ack  input  1  consumer acknowledge; clears data_valid.
REQ-007 data_out  output  8  last good received byte.
REQ-008 data_valid  output  1  data_out holds an unacknowledged byte.
REQ-009 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-clk pulse: good frame dropped because data_valid was still set.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Frame SHALL be 10 bits: start (0), 8 data bits LSB first, stop (1).
REQ-013 rx_in SHALL pass through a 2-flop synchronizer (rx_s), both flops reset to 1; rx_s is the only line value used.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE; sample counter cnt and bit index idx SHALL advance only on sample_en.
REQ-015 IDLE: on sample_en with rx_s=0 -> START, cnt=0.
REQ-016 START: on sample_en, cnt increments; on the sample_en where cnt=OVERSAMPLE/2-1, sample rx_s: 0 -> DATA, cnt=0, idx=0; 1 -> IDLE (glitch, no error flagged).
REQ-017 DATA: on the sample_en where cnt=OVERSAMPLE-1, shift rx_s into bit idx of the shift register, cnt=0, idx+1; after idx=7 is sampled -> STOP.
REQ-018 STOP: on the sample_en where cnt=OVERSAMPLE-1, sample rx_s: 1 -> IDLE and deliver the byte per REQ-019/020; 0 -> WAIT_IDLE, frame_err pulses, byte discarded.
REQ-019 Delivery when data_valid=0 or data_ack=1 in the same clk: data_out <= byte, data_valid=1 from the next clk.
REQ-020 Delivery when data_valid=1 and data_ack=0: byte dropped, data_out unchanged, overrun pulses one clk.
REQ-021 data_ack with no simultaneous delivery SHALL clear data_valid on the next clk; data_ack with data_valid=0 has no effect.
REQ-022 WAIT_IDLE: on sample_en with rx_s=1 -> IDLE; a held-low (break) line SHALL produce exactly one frame_err.
REQ-023 frame_err and overrun SHALL assert in the clk after the stop-bit sample_en.
REQ-024 sample_en absent SHALL freeze all frame state; data_ack handling continues.

Reset
REQ-025 On reset: state=IDLE, cnt=0, idx=0, shift register=0, data_out=8'h00, data_valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no frame_err or overrun; reception resumes from the next falling edge after reset deasserts.

Verification (OVERSAMPLE=16, sample_en every 4 clks)
REQ-027 Frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> data_out=8'hA5, data_valid=1 one clk after stop sample; busy low after.
REQ-028 rx_in low for 4 sample_en, then high -> returns to IDLE; no data_valid, no frame_err.
REQ-029 Frame 0x3C with stop bit 0, line held low 40 sample_en -> single frame_err pulse, data_valid stays 0, busy high until line high.
REQ-030 Frames 0x3C then 0xC3, no ack -> overrun pulse after second frame; data_out=8'h3C, data_valid=1.
REQ-031 data_ack in the same clk as delivery of 0xC3 with 0x3C pending -> data_out=8'hC3, data_valid stays 1, no overrun.
REQ-032 reset asserted during data bit 4 of 0xFF -> all outputs at reset values; next frame 0x5A received correctly.

Source files
------------

// File: rtl/ten_bit_shift_rx.sv
// ten_bit_shift_rx: oversampled 8N1 serial receiver with a one-byte holding register.
module ten_bit_shift_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       sample_en,
  input  logic       data_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, WAIT_IDLE = 3'd4;
  logic          rx_m, rx_s;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      sh         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_m      <= rx_in;
      rx_s      <= rx_m;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (data_ack) data_valid <= 1'b0;
      if (sample_en) begin
        case (state)
          IDLE: if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
          START: if (cnt == HALF) begin
            state <= rx_s ? IDLE : DATA;
            cnt   <= '0;
            idx   <= '0;
          end else cnt <= cnt + 1'b1;
          DATA: if (cnt == LAST) begin
            sh[idx] <= rx_s;
            cnt     <= '0;
            idx     <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
          STOP: if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              // a simultaneous ack frees the holding register for the new byte
              if (!data_valid || data_ack) begin
                data_out   <= sh;
                data_valid <= 1'b1;
              end else overrun <= 1'b1;
            end else begin
              state     <= WAIT_IDLE;
              frame_err <= 1'b1;
            end
          end else cnt <= cnt + 1'b1;
          WAIT_IDLE: if (rx_s) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
